wqe_fetch_scheduler: RTL and testbench

- Sequences WQE fetch requests from per-QP send queues into the single shared WQE DMA-read engine.
- Picks one eligible QP by round-robin and issues a fetch command over a valid/ready handshake.
- Tracks outstanding fetches per QP and in total against credit limits, and returns credits on completion.
- Sits between the per-QP WQE caches / QP activity table and the WQE fetch DMA engine in the TX path.

---
 rtl/wqe_fetch_scheduler.sv | 121 ++++++++++++
 tb/tb_wqe_fetch_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wqe_fetch_scheduler.sv
`default_nettype none
// wqe_fetch_scheduler: round-robin WQE fetch arbiter with per-QP and total credit tracking.
// Revision: 1.0
module wqe_fetch_scheduler #(
  parameter int MAX_QP       = 16,
  parameter int QP_PTR_WIDTH = 4,
  parameter int QP_CREDIT    = 2,
  parameter int TOTAL_CREDIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MAX_QP-1:0]       i_active,
  input  logic [MAX_QP-1:0]       i_wqe_cache_alfull,
  output logic                    o_fetch_val,
  input  logic                    i_fetch_ready,
  output logic [QP_PTR_WIDTH-1:0] o_fetch_qp_idx,
  output logic [MAX_QP-1:0]       o_fetch_qp_one_hot,
  input  logic                    i_cpl_val,
  input  logic [QP_PTR_WIDTH-1:0] i_cpl_qp_idx,
  output logic [3:0]              o_total_outstanding,
  output logic                    o_err
);

  localparam int c_cnt_w = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_cnt_w-1:0]      r_cnt [MAX_QP];
  logic [3:0]              r_total;
  logic [QP_PTR_WIDTH-1:0] r_ptr;
  logic [QP_PTR_WIDTH-1:0] r_grant;
  logic [MAX_QP-1:0]       r_one_hot;
  logic                    r_err;
  logic [MAX_QP-1:0]       w_elig;
  logic [QP_PTR_WIDTH-1:0] w_pick;
  logic                    w_found;
  logic                    w_accept;
  logic                    w_cpl_ok;

  always_comb begin
    w_elig = '0;
    for (int q = 0; q < MAX_QP; q++) begin
      w_elig[q] = i_active[q] & ~i_wqe_cache_alfull[q]
                & (r_cnt[q] < c_cnt_w'(QP_CREDIT))
                & (r_total < 4'(TOTAL_CREDIT));
    end
  end

  // Offset MAX_QP wraps to the pointer itself, so the last granted QP is checked last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int k = 1; k <= MAX_QP; k++) begin
      if (!w_found && w_elig[r_ptr + QP_PTR_WIDTH'(k)]) begin
        w_found = 1'b1;
        w_pick  = r_ptr + QP_PTR_WIDTH'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (|w_elig) w_state_nxt = S_ARB;
      S_ARB:   w_state_nxt = w_found ? S_ISSUE : S_IDLE;
      S_ISSUE: if (i_fetch_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_ISSUE) & i_fetch_ready;
  assign w_cpl_ok = i_cpl_val & (r_cnt[i_cpl_qp_idx] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= QP_PTR_WIDTH'(MAX_QP - 1);
      r_grant   <= '0;
      r_one_hot <= '0;
      r_total   <= '0;
      r_err     <= 1'b0;
      for (int q = 0; q < MAX_QP; q++) begin
        r_cnt[q] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_ARB && w_found) begin
        r_grant   <= w_pick;
        r_one_hot <= {{(MAX_QP-1){1'b0}}, 1'b1} << w_pick;
      end
      if (w_accept) begin
        r_ptr     <= r_grant;
        r_one_hot <= '0;
      end
      if (i_cpl_val && !w_cpl_ok) begin
        r_err <= 1'b1;
      end
      r_total <= r_total + {3'b000, w_accept} - {3'b000, w_cpl_ok};
      // Same-QP issue and completion cancel out through the +1/-1 pair.
      for (int q = 0; q < MAX_QP; q++) begin
        r_cnt[q] <= r_cnt[q]
                  + c_cnt_w'(w_accept && (r_grant == QP_PTR_WIDTH'(q)))
                  - c_cnt_w'(w_cpl_ok && (i_cpl_qp_idx == QP_PTR_WIDTH'(q)));
      end
    end
  end

  assign o_fetch_val         = (r_state == S_ISSUE);
  assign o_fetch_qp_idx      = r_grant;
  assign o_fetch_qp_one_hot  = r_one_hot;
  assign o_total_outstanding = r_total;
  assign o_err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wqe_fetch_scheduler.sv
`default_nettype none
// tb_wqe_fetch_scheduler: table-driven vectors plus directed multi-cycle sequences.
// Revision: 1.0
module tb_wqe_fetch_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_active = '0;
  logic [15:0] i_wqe_cache_alfull = '0;
  logic        i_fetch_ready = 1'b0;
  logic        i_cpl_val = 1'b0;
  logic [3:0]  i_cpl_qp_idx = '0;
  logic        o_fetch_val;
  logic [3:0]  o_fetch_qp_idx;
  logic [15:0] o_fetch_qp_one_hot;
  logic [3:0]  o_total_outstanding;
  logic        o_err;

  int n_tot = 0;
  int n_bad = 0;

  wqe_fetch_scheduler #(
    .MAX_QP(16), .QP_PTR_WIDTH(4), .QP_CREDIT(2), .TOTAL_CREDIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_active(i_active),
    .i_wqe_cache_alfull(i_wqe_cache_alfull),
    .o_fetch_val(o_fetch_val),
    .i_fetch_ready(i_fetch_ready),
    .o_fetch_qp_idx(o_fetch_qp_idx),
    .o_fetch_qp_one_hot(o_fetch_qp_one_hot),
    .i_cpl_val(i_cpl_val),
    .i_cpl_qp_idx(i_cpl_qp_idx),
    .o_total_outstanding(o_total_outstanding),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] active;
    logic [15:0] alfull;
    logic        cpl_val;
    logic [3:0]  cpl_idx;
    logic        e_val;
    logic [3:0]  e_idx;
    logic [3:0]  e_total;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] act, input logic [15:0] alf, input logic cv,
                     input logic [3:0] ci, input logic ev, input logic [3:0] ei,
                     input logic [3:0] et, input logic ee);
    vec_t v;
    v.active = act; v.alfull = alf; v.cpl_val = cv; v.cpl_idx = ci;
    v.e_val = ev; v.e_idx = ei; v.e_total = et; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_val(input string nm);
    int k;
    k = 0;
    while (!o_fetch_val && k < 10) begin
      tick();
      k++;
    end
    chk(nm, {31'd0, o_fetch_val}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_active = '0; i_wqe_cache_alfull = '0; i_fetch_ready = 1'b0;
    i_cpl_val = 1'b0; i_cpl_qp_idx = '0;
    tick();
    tick();
    chk("rst_val", {31'd0, o_fetch_val}, 32'd0);
    chk("rst_idx", {28'd0, o_fetch_qp_idx}, 32'd0);
    chk("rst_onehot", {16'd0, o_fetch_qp_one_hot}, 32'd0);
    chk("rst_total", {28'd0, o_total_outstanding}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [15:0] oh;

    // active, alfull, cpl_val, cpl_idx | exp val, idx, total, err
    add(16'h0001, 16'h0000, 0, 0,  0, 0, 0, 0);
    add(16'h0001, 16'h0000, 0, 0,  1, 0, 0, 0);
    add(16'h0001, 16'h0000, 0, 0,  0, 0, 1, 0);
    add(16'h0004, 16'h0000, 0, 0,  0, 0, 1, 0);
    add(16'h0004, 16'h0000, 0, 0,  1, 2, 1, 0);
    add(16'h0004, 16'h0000, 0, 0,  0, 0, 2, 0);
    add(16'h0004, 16'h0000, 0, 0,  0, 0, 2, 0);
    add(16'h0004, 16'h0000, 0, 0,  1, 2, 2, 0);
    add(16'h0004, 16'h0000, 0, 0,  0, 0, 3, 0);
    add(16'h0004, 16'h0000, 0, 0,  0, 0, 3, 0);
    add(16'h0004, 16'h0000, 0, 0,  0, 0, 3, 0);
    add(16'h0004, 16'h0000, 1, 2,  0, 0, 2, 0);
    add(16'h0004, 16'h0000, 0, 0,  0, 0, 2, 0);
    add(16'h0004, 16'h0000, 0, 0,  1, 2, 2, 0);
    add(16'h0004, 16'h0000, 0, 0,  0, 0, 3, 0);
    add(16'h0000, 16'h0000, 1, 5,  0, 0, 3, 1);
    add(16'h0000, 16'h0000, 0, 0,  0, 0, 3, 1);
    add(16'h0000, 16'h0000, 1, 0,  0, 0, 2, 1);
    add(16'h0001, 16'h0001, 0, 0,  0, 0, 2, 1);
    add(16'h0001, 16'h0001, 0, 0,  0, 0, 2, 1);
    add(16'h0001, 16'h0000, 0, 0,  0, 0, 2, 1);
    add(16'h0001, 16'h0000, 0, 0,  1, 0, 2, 1);
    add(16'h0001, 16'h0000, 0, 0,  0, 0, 3, 1);

    do_reset();
    i_fetch_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      i_active = vecs[i].active;
      i_wqe_cache_alfull = vecs[i].alfull;
      i_cpl_val = vecs[i].cpl_val;
      i_cpl_qp_idx = vecs[i].cpl_idx;
      tick();
      oh = vecs[i].e_val ? (16'h0001 << vecs[i].e_idx) : 16'h0000;
      chk($sformatf("vec%0d_val", i), {31'd0, o_fetch_val}, {31'd0, vecs[i].e_val});
      if (vecs[i].e_val)
        chk($sformatf("vec%0d_idx", i), {28'd0, o_fetch_qp_idx}, {28'd0, vecs[i].e_idx});
      chk($sformatf("vec%0d_onehot", i), {16'd0, o_fetch_qp_one_hot}, {16'd0, oh});
      chk($sformatf("vec%0d_total", i), {28'd0, o_total_outstanding}, {28'd0, vecs[i].e_total});
      chk($sformatf("vec%0d_err", i), {31'd0, o_err}, {31'd0, vecs[i].e_err});
    end
    i_cpl_val = 1'b0;

    // Round robin over all QPs with a completion returned after each accept.
    do_reset();
    i_active = 16'hFFFF;
    i_fetch_ready = 1'b1;
    for (int g = 0; g < 17; g++) begin
      tick();
      wait_val("rr_val");
      chk("rr_idx", {28'd0, o_fetch_qp_idx}, g % 16);
      oh = 16'h0001 << (g % 16);
      chk("rr_onehot", {16'd0, o_fetch_qp_one_hot}, {16'd0, oh});
      tick();
      i_cpl_val = 1'b1;
      i_cpl_qp_idx = 4'(g % 16);
      tick();
      i_cpl_val = 1'b0;
    end
    chk("rr_total", {28'd0, o_total_outstanding}, 32'd0);
    chk("rr_err", {31'd0, o_err}, 32'd0);

    // Total credit exhaustion: 8 grants to QPs 0..7, then stall.
    do_reset();
    i_active = 16'hFFFF;
    i_fetch_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (o_fetch_val) begin
        chk("cr_idx", {28'd0, o_fetch_qp_idx}, n);
        n++;
      end
    end
    chk("cr_count", n, 32'd8);
    chk("cr_total", {28'd0, o_total_outstanding}, 32'd8);
    chk("cr_stall", {31'd0, o_fetch_val}, 32'd0);

    // Held command under backpressure with i_active withdrawn.
    do_reset();
    i_active = 16'h0010;
    i_fetch_ready = 1'b0;
    tick();
    wait_val("hold_val");
    chk("hold_idx0", {28'd0, o_fetch_qp_idx}, 32'd4);
    i_active = 16'h0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_val_stable", {31'd0, o_fetch_val}, 32'd1);
      chk("hold_idx_stable", {28'd0, o_fetch_qp_idx}, 32'd4);
    end
    i_fetch_ready = 1'b1;
    tick();
    chk("hold_accepted", {31'd0, o_fetch_val}, 32'd0);
    chk("hold_total", {28'd0, o_total_outstanding}, 32'd1);

    // Same-cycle accept and completion on QP3 leaves cnt[3] and total unchanged.
    i_active = 16'h0008;
    i_fetch_ready = 1'b0;
    tick();
    wait_val("sc_val1");
    chk("sc_idx1", {28'd0, o_fetch_qp_idx}, 32'd3);
    i_fetch_ready = 1'b1;
    tick();
    i_fetch_ready = 1'b0;
    chk("sc_total1", {28'd0, o_total_outstanding}, 32'd2);
    wait_val("sc_val2");
    chk("sc_idx2", {28'd0, o_fetch_qp_idx}, 32'd3);
    i_fetch_ready = 1'b1;
    i_cpl_val = 1'b1;
    i_cpl_qp_idx = 4'd3;
    tick();
    i_cpl_val = 1'b0;
    chk("sc_total2", {28'd0, o_total_outstanding}, 32'd2);
    chk("sc_err", {31'd0, o_err}, 32'd0);
    n = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (o_fetch_val) n++;
    end
    chk("sc_remaining_credit", n, 32'd1);
    chk("sc_total3", {28'd0, o_total_outstanding}, 32'd3);

    // Asynchronous reset while a command is pending.
    do_reset();
    i_active = 16'h0001;
    i_fetch_ready = 1'b0;
    tick();
    wait_val("ar_val");
    #2;
    rst = 1'b1;
    #1;
    chk("ar_val_drop", {31'd0, o_fetch_val}, 32'd0);
    chk("ar_onehot_drop", {16'd0, o_fetch_qp_one_hot}, 32'd0);
    do_reset();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
